// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam int INSTR_BYTES = 4;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC: sequential step or PC-relative branch, word aligned.
module pc_next
    import fetch_unit_pkg::*;
(
    input  logic [31:0] PC,
    input  logic [31:0] ImmOp,
    input  logic        PCSrc,
    output logic [31:0] next_pc
);

    logic [31:0] w_sum;

    // Plain 32-bit adds: overflow wraps and the carry is discarded.
    assign w_sum   = PCSrc ? (PC + ImmOp) : (PC + 32'(INSTR_BYTES));
    assign next_pc = align_pc(w_sum);

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher: FETCH -> WAIT -> ISSUE, with a
// sticky FAULT when memory does not answer within TIMEOUT wait cycles.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic [31:0] ImmOp,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic        fault
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_valid;
    logic [7:0]   r_cnt;
    logic [31:0]  w_next_pc;
    logic         w_consume;
    logic         w_timeout;

    pc_next u_pc_next (
        .PC      (r_pc),
        .ImmOp   (ImmOp),
        .PCSrc   (PCSrc),
        .next_pc (w_next_pc)
    );

    assign w_consume = (r_state == ISSUE) && !stall;
    // Fires on the TIMEOUT-th consecutive wait cycle without data.
    assign w_timeout = ({1'b0, r_cnt} + 9'd1) >= 9'(TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FETCH;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH:   w_state_nxt = WAIT;
            WAIT: begin
                if (imem_rvalid)    w_state_nxt = ISSUE;
                else if (w_timeout) w_state_nxt = FAULT;
            end
            ISSUE:   if (!stall) w_state_nxt = FETCH;
            FAULT:   w_state_nxt = FAULT;
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= align_pc(RESET_PC);
            r_instr <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                FETCH: r_cnt <= '0;
                WAIT: begin
                    if (imem_rvalid) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    if (w_consume) begin
                        r_pc    <= w_next_pc;
                        r_valid <= 1'b0;
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

    // Request is gated by rst so nothing is issued while reset is held.
    assign imem_req    = (r_state == FETCH) && !rst;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign PC          = r_pc;
    assign fault       = (r_state == FAULT);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetched instruction.
REQ-002 Parameter TIMEOUT, default 255, maximum number of WAIT cycles before a fetch fault (range 1..255).
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port PCSrc, input, 1, branch-taken select from control_unit, sampled only on the consume cycle.
REQ-006 Port ImmOp, input, 32, sign-extended branch offset, sampled only on the consume cycle.
REQ-007 Port stall, input, 1, downstream hold; when high, the current instruction is not consumed.
REQ-008 Port imem_req, output, 1, one-cycle request pulse to instruction memory.
REQ-009 Port imem_addr, output, 32, fetch address; equals PC whenever imem_req=1.
REQ-010 Port imem_rvalid, input, 1, read data valid from instruction memory.
REQ-011 Port imem_rdata, input, 32, instruction word, valid when imem_rvalid=1.
REQ-012 Port instr, output, 32, registered instruction presented to control_unit.
REQ-013 Port instr_valid, output, 1, instr is valid for the current PC.
REQ-014 Port PC, output, 32, address of the instruction in instr.
REQ-015 Port fault, output, 1, sticky fetch-timeout indication.

Function
REQ-016 The FSM SHALL have states FETCH, WAIT, ISSUE and FAULT.
REQ-017 In FETCH: imem_req=1 and imem_addr=PC; next state is always WAIT.
REQ-018 In WAIT: imem_req=0; on imem_rvalid=1, instr<=imem_rdata, instr_valid<=1, go to ISSUE; imem_rvalid outside WAIT is ignored.
REQ-019 In WAIT, an 8-bit counter increments each cycle without imem_rvalid; when it reaches TIMEOUT, go to FAULT (rvalid in that same cycle wins and goes to ISSUE).
REQ-020 The counter SHALL clear on entry to WAIT.
REQ-021 Consume cycle = ISSUE and stall=0: PC<=next_pc, instr_valid<=0, next state FETCH.
REQ-022 In ISSUE with stall=1: PC, instr and instr_valid are held unchanged indefinitely.
REQ-023 next_pc SHALL be PC+ImmOp when PCSrc=1, else PC+4; both computed modulo 2^32 (wrap-around, no carry out).
REQ-024 next_pc[1:0] SHALL be forced to 2'b00.
REQ-025 FAULT is terminal until reset: fault=1, imem_req=0, instr_valid=0.
REQ-026 Minimum issue period SHALL be 3 cycles per instruction (FETCH, WAIT with 1-cycle memory latency, ISSUE).
REQ-027 At most one memory request SHALL be outstanding at any time.

Reset
REQ-028 While rst=1: state=FETCH, PC=RESET_PC with [1:0] forced to 00, instr=0, instr_valid=0, fault=0, counter=0, imem_req=0.
REQ-029 The first imem_req SHALL occur in the first clock cycle after rst deasserts.
REQ-030 Reset asserted mid-WAIT abandons the request; a late imem_rvalid after reset is ignored because state is FETCH.

Structure
REQ-031 A shared package SHALL hold the state enum fetch_state_t and the constant INSTR_BYTES=4.
REQ-032 next-PC arithmetic SHALL be a sub-module pc_next (inputs PC, ImmOp, PCSrc; output next_pc), purely combinational.

Verification
REQ-033 Reset release with 1-cycle memory -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid high on every third cycle.
REQ-034 Consume at PC=0x10 with PCSrc=1 and ImmOp=0xFFFF_FFF8 -> next imem_addr=0x08.
REQ-035 stall held high for 5 cycles in ISSUE -> PC and instr unchanged, no imem_req; FETCH follows one cycle after stall drops.
REQ-036 PC=0xFFFF_FFFC with PCSrc=0 -> next imem_addr=0x0000_0000; PCSrc=1 with ImmOp=0x6 at PC=0x0 -> 0x4.
REQ-037 TIMEOUT=4 and no imem_rvalid -> fault=1 exactly 4 WAIT cycles after the request; stays 1 until rst, then PC=RESET_PC.
REQ-038 rst asserted during WAIT, then imem_rvalid pulsed -> instr_valid stays 0 and refetch starts at RESET_PC.
